// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the ALU command sequencer: op selects, FSM states and
// flag bit positions inside rsp_flags.
package alu_seq_ctrl_pkg;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_CMP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

endpackage

// File: rtl/alu_seq_cnt.sv
// CNT_W event counter with enable; SATURATE selects hold-at-all-ones
// instead of wrapping. Synchronous active-high reset clears it.
module alu_seq_cnt #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_hold;

  assign w_hold = SATURATE && (&r_count);

  always_ff @(posedge clk) begin
    if (rst)                  r_count <= '0;
    else if (i_en && !w_hold) r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/four_bit_ALU.sv
// Combinational 4-bit ALU driven by the sequencer: 5-bit add/sub result,
// 4-bit AND result and magnitude-compare flags, all computed every cycle.
module four_bit_ALU (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [1:0] i_sel,
  output logic [4:0] o_yAddSub,
  output logic [3:0] o_yAnd,
  output logic       o_eq,
  output logic       o_gt,
  output logic       o_lt
);

  // SUB yields a 5-bit two's complement difference; every other select adds
  always_comb begin
    if (i_sel == 2'b01) o_yAddSub = {1'b0, i_a} - {1'b0, i_b};
    else                o_yAddSub = {1'b0, i_a} + {1'b0, i_b};
  end

  assign o_yAnd = i_a & i_b;
  assign o_eq   = (i_a == i_b);
  assign o_gt   = (i_a > i_b);
  assign o_lt   = (i_a < i_b);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of four_bit_ALU: accept, hold operands for
// SETTLE_CYCLES, capture, respond. ALU_SEQ_CTRL_OVF_CNT_EN builds ovf_cnt.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_sel,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_chain,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [4:0]       alu_y_addsub,
  input  logic [3:0]       alu_y_and,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_lt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1) begin : g_badSettle
    $error("alu_seq_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_t              r_state, w_nextState;
  logic [SETTLE_W-1:0] r_settleCnt;
  logic [3:0]          r_aluA, r_aluB;
  logic [1:0]          r_aluSel;
  logic [4:0]          r_rspData;
  logic [2:0]          r_rspFlags;
  logic [4:0]          w_result;
  logic [2:0]          w_flags;
  logic                w_cmdReady, w_accept, w_capture, w_handshake;

  // Held low while rst is asserted so the requester never sees ready during reset
  assign w_cmdReady = (r_state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: if (cmd_valid && w_cmdReady) begin
        w_accept    = 1'b1;
        w_nextState = ST_EXEC;
      end
      ST_EXEC: if (r_settleCnt == '0) begin
        w_capture   = 1'b1;
        w_nextState = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        w_handshake = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                       r_settleCnt <= '0;
    else if (w_accept)                             r_settleCnt <= SETTLE_W'(SETTLE_CYCLES - 1);
    else if (r_state == ST_EXEC && r_settleCnt != '0) r_settleCnt <= r_settleCnt - SETTLE_W'(1);
  end

  always_comb begin
    w_result = '0;
    case (r_aluSel)
      SEL_ADD, SEL_SUB: w_result = alu_y_addsub;
      SEL_AND:          w_result = {1'b0, alu_y_and};
      default:          w_result = '0;
    endcase
    w_flags          = '0;
    w_flags[FLAG_EQ] = alu_eq;
    w_flags[FLAG_GT] = alu_gt;
    w_flags[FLAG_LT] = alu_lt;
  end

  // r_rspData doubles as last_result for chained operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluSel   <= '0;
      r_rspData  <= '0;
      r_rspFlags <= '0;
    end else begin
      if (w_accept) begin
        r_aluSel <= cmd_sel;
        r_aluB   <= cmd_b;
        r_aluA   <= cmd_chain ? r_rspData[3:0] : cmd_a;
      end
      if (w_capture) begin
        r_rspData  <= w_result;
        r_rspFlags <= w_flags;
      end
    end
  end

  alu_seq_cnt #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_opCnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_handshake),
    .o_count (op_cnt)
  );

`ifdef ALU_SEQ_CTRL_OVF_CNT_EN
  logic w_ovfEvent;
  assign w_ovfEvent = w_capture && (r_aluSel == SEL_ADD) && alu_y_addsub[4];

  alu_seq_cnt #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_ovfCnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ovfEvent),
    .o_count (ovf_cnt)
  );
`else
  assign ovf_cnt = '0;
`endif

  assign cmd_ready = w_cmdReady;
  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_sel   = r_aluSel;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rspData;
  assign rsp_flags = r_rspFlags;
  assign busy      = (r_state != ST_IDLE);

endmodule
